// File: rtl/mux_select_arbiter_pkg.sv
// Purpose: shared types and constants for the 8:1 bit-select arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mux_select_arbiter_pkg;

  // Number of requesters sharing the bit-select path.
  localparam int NUM_REQ = 8;

  // Width of the selector / pointer.
  localparam int SEL_W = 3;

  // Width of the hold counter.
  localparam int HOLD_W = 8;

  // Default maximum consecutive ownership cycles (legal range 2..255).
  localparam int DEFAULT_MAX_HOLD = 16;

  // Arbiter states.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_OWNED      = 2'd1,
    ST_TURNAROUND = 2'd2
  } state_e;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_select_arbiter_rr_priority_pick.sv
// Purpose: wrapped priority search -- first set request bit at or above pointer, wrapping 7->0.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of request and pointer.
module rr_priority_pick
  import mux_select_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] request,
  input  logic [SEL_W-1:0]   pointer,
  output logic               found,
  output logic [SEL_W-1:0]   index
);

  logic [SEL_W-1:0] w_probe;

  // Scan offsets from farthest to nearest so the nearest set bit is the last one written.
  always_comb begin
    found   = 1'b0;
    index   = '0;
    w_probe = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_probe = pointer + SEL_W'(k);
      if (request[w_probe]) begin
        found = 1'b1;
        index = w_probe;
      end
    end
  end

endmodule

// File: rtl/mux_select_arbiter.sv
// Purpose: round-robin owner arbitration for a shared 8:1 bit-select path with a hold limit.
// Latency: grant registered 1 cycle after request is sampled in IDLE; release costs TURNAROUND + IDLE.
// Backpressure: none; an owner keeps the path until it drops request or hits MAX_HOLD.
module mux_select_arbiter
#(
  parameter int MAX_HOLD = mux_select_arbiter_pkg::DEFAULT_MAX_HOLD
)
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] request,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic [2:0] selector,
  output logic       timeout
);

  import mux_select_arbiter_pkg::*;

  // Last hold_count value an owner may reach before being forced off.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e              r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_grant_valid;
  logic [SEL_W-1:0]    r_selector;
  logic                r_timeout;
  logic [SEL_W-1:0]    r_pointer;
  logic [HOLD_W-1:0]   r_hold_count;

  logic                w_found;
  logic [SEL_W-1:0]    w_index;
  logic                w_owner_req;

  // Wrapped search starting at the round-robin pointer.
  rr_priority_pick u_pick (
    .request (request),
    .pointer (r_pointer),
    .found   (w_found),
    .index   (w_index)
  );

  // Current owner is still asking for the path; selector always names the owner while OWNED.
  assign w_owner_req = request[r_selector];

  // Arbiter FSM; every output is a register so grant and selector always change together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_selector    <= '0;
      r_timeout     <= 1'b0;
      r_pointer     <= '0;
      r_hold_count  <= '0;
    end else begin
      // timeout is a single-cycle pulse unless re-armed below.
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant       <= idx_to_onehot(w_index);
            r_grant_valid <= 1'b1;
            r_selector    <= w_index;
            r_pointer     <= w_index + SEL_W'(1);
            r_hold_count  <= '0;
            r_state       <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (!w_owner_req) begin
            // Voluntary release wins even on the last allowed cycle.
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_state       <= ST_TURNAROUND;
          end else if (r_hold_count == HOLD_LAST) begin
            // Hold limit reached with request still high: force the owner off.
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b1;
            r_state       <= ST_TURNAROUND;
          end else begin
            r_hold_count  <= r_hold_count + HOLD_W'(1);
          end
        end
        ST_TURNAROUND: begin
          // One dead cycle; request is not looked at here. Selector keeps its value.
          r_state <= ST_IDLE;
        end
        default: begin
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign selector    = r_selector;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Purpose: directed self-checking bench for mux_select_arbiter with MAX_HOLD=4.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_mux_select_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] request = 8'h00;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] selector;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_select_arbiter #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .request     (request),
    .grant       (grant),
    .grant_valid (grant_valid),
    .selector    (selector),
    .timeout     (timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] sel,
                         input logic to);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(g != 8'h00));
    chk({tag, ".selector"}, 32'(selector), 32'(sel));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    // Reset state.
    reset_n = 1'b0;
    request = 8'h00;
    step();
    step();
    chk_out("reset", 8'h00, 3'd0, 1'b0);
    reset_n = 1'b1;

    // Single request to 4, then drop: one TURNAROUND, selector holds.
    request = 8'h10;
    step();
    chk_out("single.grant", 8'h10, 3'd4, 1'b0);
    request = 8'h00;
    step();
    chk_out("single.turn", 8'h00, 3'd4, 1'b0);
    step();
    chk_out("single.idle", 8'h00, 3'd4, 1'b0);

    // Timeout: pointer at 5, request 0 wraps, held 4 cycles then forced off.
    request = 8'h01;
    step();
    chk_out("to.grant", 8'h01, 3'd0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_out("to.hold", 8'h01, 3'd0, 1'b0);
    end
    step();
    chk_out("to.pulse", 8'h00, 3'd0, 1'b1);
    step();
    chk_out("to.idle", 8'h00, 3'd0, 1'b0);
    step();
    chk_out("to.regrant", 8'h01, 3'd0, 1'b0);
    request = 8'h00;
    step();
    step();

    // Contention: pointer 1 with 0x81 picks 7; after timeout 0 wins.
    request = 8'h81;
    step();
    chk_out("cont.grant7", 8'h80, 3'd7, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_out("cont.hold7", 8'h80, 3'd7, 1'b0);
    end
    step();
    chk_out("cont.pulse", 8'h00, 3'd7, 1'b1);
    step();
    chk_out("cont.idle", 8'h00, 3'd7, 1'b0);
    step();
    chk_out("cont.grant0", 8'h01, 3'd0, 1'b0);
    request = 8'h00;
    step();
    step();

    // Boundary: owner drops exactly when hold_count is at MAX_HOLD-1.
    request = 8'h01;
    step();
    chk_out("bnd.grant", 8'h01, 3'd0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_out("bnd.hold", 8'h01, 3'd0, 1'b0);
    end
    request = 8'h00;
    step();
    chk_out("bnd.release", 8'h00, 3'd0, 1'b0);
    step();
    chk_out("bnd.after", 8'h00, 3'd0, 1'b0);

    // Non-owner request ignored during ownership; then one-cycle grant on immediate drop.
    request = 8'h04;
    step();
    chk_out("nonown.grant2", 8'h04, 3'd2, 1'b0);
    request = 8'h0C;
    step();
    chk_out("nonown.keep2", 8'h04, 3'd2, 1'b0);
    request = 8'h08;
    step();
    chk_out("nonown.turn", 8'h00, 3'd2, 1'b0);
    step();
    chk_out("nonown.idle", 8'h00, 3'd2, 1'b0);
    step();
    chk_out("nonown.grant3", 8'h08, 3'd3, 1'b0);
    request = 8'h00;
    step();
    chk_out("oneshot.drop", 8'h00, 3'd3, 1'b0);
    step();

    // Reset mid-ownership: immediate clear, pointer back to 0.
    request = 8'h20;
    step();
    chk_out("rst.grant5", 8'h20, 3'd5, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("rst.async", 8'h00, 3'd0, 1'b0);
    request = 8'h22;
    step();
    reset_n = 1'b1;
    step();
    chk_out("rst.after", 8'h02, 3'd1, 1'b0);
    request = 8'h00;
    step();
    step();

    // All requesting from reset: order 0..7 then 0, each holds 2 cycles.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    request = 8'hFF;
    step();
    chk_out("all.first", 8'h01, 3'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] cur;
      logic [7:0] nxt;
      logic [2:0] kn;
      cur = 8'h01 << k;
      kn  = 3'(k + 1);
      nxt = 8'h01 << kn;
      step();
      chk_out("all.hold", cur, 3'(k), 1'b0);
      request = 8'hFF & ~cur;
      step();
      chk_out("all.turn", 8'h00, 3'(k), 1'b0);
      request = 8'hFF;
      step();
      chk_out("all.idle", 8'h00, 3'(k), 1'b0);
      step();
      chk_out("all.next", nxt, kn, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_select_arbiter.md
MUX_SELECT_ARBITER -- requirements
Module: mux_select_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter MAX_HOLD, default 16, SHALL set the maximum consecutive cycles one owner holds the shared 8:1 bit-select path (legal 2..255).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 request  input  8  per-requester request for the shared bit-select path; bit i = requester i.
REQ-006 grant  output  8  one-hot ownership; all-zero when no owner.
REQ-007 grant_valid  output  1  high while any grant bit is high.
REQ-008 selector  output  3  binary index of the current or last owner; drives the bit mux select.
REQ-009 timeout  output  1  one-cycle pulse when an owner is forcibly released at MAX_HOLD.

Function
REQ-010 The FSM SHALL have states IDLE, OWNED and TURNAROUND.
REQ-011 In IDLE, if request is non-zero, the block SHALL register grant to the first set bit searching upward from pointer with wrap 7->0, and enter OWNED; grant latency is 1 cycle from request sampled.
REQ-012 In IDLE with request all-zero, the block SHALL stay in IDLE with grant 0.
REQ-013 On grant to index i, the block SHALL load selector=i, set pointer=(i+1) mod 8 (3-bit wrap), and clear hold_count to 0.
REQ-014 In OWNED, hold_count SHALL increment by 1 per cycle while request[owner] stays high.
REQ-015 In OWNED, request[owner] low SHALL end ownership: grant cleared next edge, state -> TURNAROUND, no timeout pulse.
REQ-016 In OWNED, hold_count reaching MAX_HOLD-1 with request[owner] high SHALL force release: grant cleared, timeout=1 for one cycle, state -> TURNAROUND.
REQ-017 If request[owner] drops on the same cycle hold_count reaches MAX_HOLD-1, the release SHALL be treated as normal (REQ-015), timeout=0.
REQ-018 TURNAROUND SHALL last exactly 1 cycle with grant=0, then go to IDLE; request is not sampled in TURNAROUND.
REQ-019 Request changes of non-owners during OWNED SHALL be ignored until the next IDLE arbitration.
REQ-020 selector SHALL hold its last value in IDLE and TURNAROUND (no glitch to 0).
REQ-021 A requester dropping request in the cycle its grant is issued SHALL still receive grant for exactly one cycle.
REQ-022 A timed-out requester SHALL be re-granted only if no other requester is set at the next IDLE arbitration (pointer has advanced past it).
REQ-023 All outputs SHALL be registered; grant and selector SHALL always be consistent (grant = 1<<selector whenever grant_valid).

Reset
REQ-024 On reset_n low, asynchronously: state=IDLE, grant=0, grant_valid=0, selector=0, timeout=0, pointer=0, hold_count=0.
REQ-025 Reset asserted mid-ownership SHALL drop grant immediately, with no timeout pulse; first arbitration after deassertion starts at pointer 0.

Structure
REQ-026 State encodings and the default MAX_HOLD SHALL be defined once in the shared package.
REQ-027 The wrapped priority search SHALL be a sub-module rr_priority_pick (inputs request[7:0], pointer[2:0]; outputs found, index[2:0]), combinational.
REQ-028 hold_count SHALL be 8 bits wide.

Verification
REQ-029 Single request: request=8'h10 from reset -> 1 cycle later grant=8'h10, selector=4; drop request -> grant=0 next edge, one TURNAROUND cycle.
REQ-030 All requesting: request=8'hFF, each owner drops after 2 cycles -> grant order 0,1,2,...,7,0 with one idle TURNAROUND cycle between owners.
REQ-031 Timeout: MAX_HOLD=4, request=8'h01 held -> grant for 4 cycles, timeout pulses 1 cycle, grant=0, then re-granted to 0 after TURNAROUND.
REQ-032 Timeout with contention: MAX_HOLD=4, request=8'h81 held, owner 7 -> after timeout next grant is 0, selector=0.
REQ-033 Boundary: owner drops request on the cycle hold_count=MAX_HOLD-1 -> timeout stays 0.
REQ-034 Reset mid-operation: reset_n low while grant=8'h20 -> grant=0, selector=0 immediately; after release, request=8'h22 -> grant=8'h02.
